add64_sequencer: RTL and testbench

Sequencer that performs a 64-bit unsigned addition by time-multiplexing the calculator's shared 32-bit carry-less adder (`adder32`), which has no carry input or output. It accepts a 64-bit operand pair through a valid/ready handshake and drives the adder over three passes: low half, carry injection, high half. It recovers inter-half carries by unsigned comparison and returns the 64-bit sum through a valid/ready handshake. It sits directly upstream of `adder32`, feeding its operands, and directly downstream of it, consuming its sum.

---
 rtl/add64_sequencer.sv | 151 +++++++++++++++
 tb/tb_add64_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add64_sequencer.sv
// add64_sequencer: 64-bit unsigned add built from three passes (low, carry-in, high) through a
// shared carry-less DATA_W-bit adder. Define ADD64_CARRY_EN to add the carry_o port.
module add64_sequencer #(
  parameter int DATA_W = 32  // matches calculator_pkg adder width
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [2*DATA_W-1:0] op_a_i,
  input  logic [2*DATA_W-1:0] op_b_i,
  output logic [DATA_W-1:0]   adder_a_o,
  output logic [DATA_W-1:0]   adder_b_o,
  input  logic [DATA_W-1:0]   adder_sum_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [2*DATA_W-1:0] result_o,
`ifdef ADD64_CARRY_EN
  output logic                carry_o,
`endif
  output logic [2:0]          dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Input side accepts only in IDLE; the result is held with out_valid_o high until taken.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_CIN  = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [2*DATA_W-1:0] r_a;
  logic [DATA_W-1:0]   r_b_hi;
  logic [DATA_W-1:0]   r_sum_lo;
  logic [DATA_W-1:0]   r_t;
  logic                r_c0;
  logic [DATA_W-1:0]   r_adder_a;
  logic [DATA_W-1:0]   r_adder_b;
  logic [2*DATA_W-1:0] r_result;
  logic                r_out_valid;
  logic                w_c0;
  logic                w_c2;
  logic                w_a_hi_ones;
`ifdef ADD64_CARRY_EN
  logic                r_c1;
  logic                r_c2;
`endif

  // Carries are recovered by unsigned comparison since the adder has no carry pins.
  assign w_c0        = (adder_sum_i < r_a[DATA_W-1:0]);
  assign w_c2        = (adder_sum_i < r_t);
  assign w_a_hi_ones = &r_a[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid_i) w_next_state = S_LO;
      S_LO:    w_next_state = S_CIN;
      S_CIN:   w_next_state = S_HI;
      S_HI:    w_next_state = S_DONE;
      S_DONE:  if (out_ready_i) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (r_state == S_IDLE) & ~rst_i;
    out_valid_o = r_out_valid;
    result_o    = r_result;
    adder_a_o   = r_adder_a;
    adder_b_o   = r_adder_b;
    dbg_state_o = r_state;
`ifdef ADD64_CARRY_EN
    carry_o     = r_out_valid & (r_c1 | r_c2);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a         <= '0;
      r_b_hi      <= '0;
      r_sum_lo    <= '0;
      r_t         <= '0;
      r_c0        <= 1'b0;
      r_adder_a   <= '0;
      r_adder_b   <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
`ifdef ADD64_CARRY_EN
      r_c1        <= 1'b0;
      r_c2        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_a       <= op_a_i;
            r_b_hi    <= op_b_i[2*DATA_W-1:DATA_W];
            r_adder_a <= op_a_i[DATA_W-1:0];
            r_adder_b <= op_b_i[DATA_W-1:0];
          end
        end
        S_LO: begin
          r_sum_lo  <= adder_sum_i;
          r_c0      <= w_c0;
          r_adder_a <= r_a[2*DATA_W-1:DATA_W];
          r_adder_b <= {{(DATA_W-1){1'b0}}, w_c0};
        end
        S_CIN: begin
          r_t       <= adder_sum_i;
`ifdef ADD64_CARRY_EN
          r_c1      <= r_c0 & w_a_hi_ones;
`endif
          r_adder_a <= adder_sum_i;
          r_adder_b <= r_b_hi;
        end
        S_HI: begin
          r_result    <= {adder_sum_i, r_sum_lo};
`ifdef ADD64_CARRY_EN
          r_c2        <= w_c2;
`endif
          r_adder_a   <= '0;
          r_adder_b   <= '0;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready_i) r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifndef ADD64_CARRY_EN
  // Carry comparisons only feed carry_o; keep them referenced in the default build.
  logic w_unused;
  assign w_unused = w_c2 ^ w_a_hi_ones;
`endif

endmodule

// File: tb/tb_add64_sequencer.sv
// Self-checking bench for add64_sequencer with a behavioural carry-less adder model.
// Carry checks are compiled in when ADD64_CARRY_EN is defined.
module tb_add64_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] op_a_i;
  logic [63:0] op_b_i;
  logic [31:0] adder_a_o;
  logic [31:0] adder_b_o;
  logic [31:0] adder_sum_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] result_o;
  logic        carry_o;
  logic [2:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic        exp_c_q[$];

  always #5 clk = ~clk;

  assign adder_sum_i = adder_a_o + adder_b_o;

`ifndef ADD64_CARRY_EN
  assign carry_o = 1'b0;
`endif

  add64_sequencer #(.DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .adder_a_o   (adder_a_o),
    .adder_b_o   (adder_b_o),
    .adder_sum_i (adder_sum_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
`ifdef ADD64_CARRY_EN
    .carry_o     (carry_o),
`endif
    .dbg_state_o (dbg_state_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic push_expected(input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    exp_q.push_back(s[63:0]);
    exp_c_q.push_back(s[64]);
  endtask

  // Called away from a clock edge; returns 1 time unit after the handshake edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b);
    int guard;
    guard = 0;
    while (in_ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready_o=%b required 1", in_ready_o);
    end
    in_valid_i = 1'b1;
    op_a_i     = a;
    op_b_i     = b;
    push_expected(a, b);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    op_a_i     = {$urandom, $urandom};
    op_b_i     = {$urandom, $urandom};
  endtask

  // Checks adder operands for each pass and the exact latency of out_valid_o.
  task automatic check_passes(input logic [63:0] a, input logic [63:0] b);
    logic [32:0] lo;
    logic        c0;
    logic [31:0] t;
    logic [31:0] ea[4];
    logic [31:0] eb[4];
    lo = {1'b0, a[31:0]} + {1'b0, b[31:0]};
    c0 = lo[32];
    t  = a[63:32] + {31'b0, c0};
    ea[0] = a[31:0];   eb[0] = b[31:0];
    ea[1] = a[63:32];  eb[1] = {31'b0, c0};
    ea[2] = t;         eb[2] = b[63:32];
    ea[3] = 32'd0;     eb[3] = 32'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({adder_a_o, adder_b_o} !== {ea[k], eb[k]}) begin
        errors++;
        $display("FAIL adder_pass%0d: a=%h b=%h required a=%h b=%h", k, adder_a_o, adder_b_o, ea[k], eb[k]);
      end
      checks++;
      if (out_valid_o !== (k == 3)) begin
        errors++;
        $display("FAIL latency_pass%0d: out_valid_o=%b required %b", k, out_valid_o, (k == 3));
      end
    end
  endtask

  // Waits for a result, stalls for 'stall' cycles, then consumes and scores it.
  task automatic recv(input int stall);
    int          guard;
    logic [63:0] held;
    logic [63:0] exp_r;
    logic        exp_c;
    guard = 0;
    while (out_valid_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL recv_timeout: out_valid_o=%b required 1", out_valid_o);
    end
    held = result_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (result_o !== held || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: result=%h valid=%b in_ready=%b required result=%h valid=1 in_ready=0",
                 result_o, out_valid_o, in_ready_o, held);
      end
    end
    out_ready_i = 1'b1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: result=%h with no expected entry", result_o);
    end else begin
      exp_r = exp_q.pop_front();
      exp_c = exp_c_q.pop_front();
      checks++;
      if (result_o !== exp_r) begin
        errors++;
        $display("FAIL result: got %h required %h", result_o, exp_r);
      end
`ifdef ADD64_CARRY_EN
      checks++;
      if (carry_o !== exp_c) begin
        errors++;
        $display("FAIL carry: got %b required %b", carry_o, exp_c);
      end
`else
      if (exp_c === 1'bx) $display("note: undefined carry model");
`endif
    end
    @(posedge clk);
    #1;
    out_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state_o !== 3'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL release_idle: state=%0d valid=%b in_ready=%b required state=0 valid=0 in_ready=1",
               dbg_state_o, out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_op(input logic [63:0] a, input logic [63:0] b, input int stall);
    send(a, b);
    check_passes(a, b);
    recv(stall);
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    op_a_i      = '0;
    op_b_i      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 0", in_ready_o);
    end
    checks++;
    if ({out_valid_o, result_o, adder_a_o, adder_b_o, carry_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b result=%h a=%h b=%h carry=%b required all 0",
               out_valid_o, result_o, adder_a_o, adder_b_o, carry_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1 || dbg_state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b state=%0d required 1 and 0", in_ready_o, dbg_state_o);
    end
  endtask

  task automatic test_basic();
    test_op(64'd1, 64'd2, 0);
  endtask

  task automatic test_lo_carry();
    test_op(64'h0000_0000_FFFF_FFFF, 64'd1, 0);
  endtask

  task automatic test_inject_carry();
    test_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0);
  endtask

  task automatic test_hi_carry();
    test_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 0);
  endtask

  task automatic test_backpressure();
    test_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 5);
    test_op(64'h0000_0001_FFFF_FFFE, 64'h0000_0002_0000_0003, 0);
  endtask

  // out_ready tied high with in_valid held: the next accept lands 5 edges after the first.
  task automatic test_back_to_back();
    logic [63:0] a2;
    logic [63:0] b2;
    int          first_ready;
    bit          got1;
    logic [63:0] exp_r;
    logic        exp_c;
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    first_ready = 0;
    got1 = 1'b0;
    out_ready_i = 1'b1;
    send({$urandom, $urandom}, {$urandom, $urandom});
    in_valid_i = 1'b1;
    op_a_i     = a2;
    op_b_i     = b2;
    for (int k = 1; k <= 8 && first_ready == 0; k++) begin
      @(negedge clk);
      if (out_valid_o === 1'b1 && !got1) begin
        got1  = 1'b1;
        exp_r = exp_q.pop_front();
        exp_c = exp_c_q.pop_front();
        checks++;
        if (k != 4 || result_o !== exp_r) begin
          errors++;
          $display("FAIL b2b_first: cycle %0d result %h required cycle 4 result %h", k, result_o, exp_r);
        end
`ifdef ADD64_CARRY_EN
        checks++;
        if (carry_o !== exp_c) begin
          errors++;
          $display("FAIL b2b_first_carry: got %b required %b", carry_o, exp_c);
        end
`endif
      end
      if (in_ready_o === 1'b1) first_ready = k;
    end
    checks++;
    if (first_ready != 5 || !got1) begin
      errors++;
      $display("FAIL b2b_accept: in_ready at cycle %0d seen_result=%b required cycle 5 and 1", first_ready, got1);
    end
    push_expected(a2, b2);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    recv(0);
  endtask

  task automatic test_mid_reset();
    send(64'hFFFF_FFFF_0000_0001, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dbg_state_o !== 3'd2) begin
      errors++;
      $display("FAIL mid_reset_cin: state=%0d required 2", dbg_state_o);
    end
    rst_i = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_c_q.pop_back());
    @(negedge clk);
    checks++;
    if ({in_ready_o, out_valid_o, result_o, adder_a_o, adder_b_o, carry_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: in_ready=%b valid=%b result=%h a=%h b=%h carry=%b required all 0",
               in_ready_o, out_valid_o, result_o, adder_a_o, adder_b_o, carry_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: in_ready=%b required 1", in_ready_o);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_dropped: out_valid_o=%b required 0", out_valid_o);
      end
    end
    test_op(64'd5, 64'd7, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_op({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lo_carry();
    test_inject_carry();
    test_hi_carry();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
